sfx_scheduler: RTL and testbench
================================

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 SHALL have parameter SHORT_DUR, default 4096, meaning short-effect play time in clk cycles.
REQ-002 SHALL have parameter LONG_DUR, default 32767, meaning long-effect play time in clk cycles.
REQ-003 SHALL have parameter GAP_LEN, default 16, meaning silent guard cycles between effects, range 1..255.
REQ-004 SHALL have port clk  input  1  sound clock (134 kHz domain); one clock only.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  4  per-source request pulses; index = source id = priority, 3 highest.
REQ-007 SHALL have port c  output  1  one-cycle trigger to the tone generator.
REQ-008 SHALL have port fxa  output  4  effect frequency code for the tone generator.
REQ-009 SHALL have port fxb  output  1  duration select: 1 = long, 0 = short.
REQ-010 SHALL have port busy  output  1  high from the trigger cycle through the last GAP cycle.
REQ-011 SHALL have port drop  output  1  one-cycle pulse when a request is lost.

Function
REQ-012 SHALL map sources to effects: 0 -> fxa=0,fxb=0 (paddle); 1 -> fxa=1,fxb=0 (wall); 2 -> fxa=2,fxb=0 (short whistle); 3 -> fxa=2,fxb=1 (long whistle).
REQ-013 SHALL hold a 4-bit pending register; req[i]=1 sets pending[i] on the next edge.
REQ-014 SHALL pulse drop for one cycle when req[i]=1 while pending[i] is already 1; pending unchanged.
REQ-015 SHALL implement states IDLE, ISSUE, PLAY, GAP.
REQ-016 IDLE: with any pending bit set, SHALL select the highest set index and enter ISSUE next cycle.
REQ-017 ISSUE: SHALL assert c for exactly one cycle, drive fxa/fxb of the selected source, clear its pending bit, load timer with SHORT_DUR or LONG_DUR per fxb, then enter PLAY.
REQ-018 If req for the source being issued arrives in the ISSUE cycle, pending SHALL remain set (set wins over clear) and drop SHALL NOT pulse.
REQ-019 PLAY: timer SHALL decrement each cycle; at timer==1 SHALL enter GAP, so PLAY lasts exactly the loaded duration.
REQ-020 GAP: SHALL count GAP_LEN cycles, then enter IDLE; pending bits set during PLAY/GAP are served afterwards.
REQ-021 fxa/fxb SHALL remain stable from ISSUE until the next ISSUE.
REQ-022 Timer SHALL be 15 bits, unsigned, never wrap below zero.
REQ-023 Requests SHALL never be lost except per REQ-014.

Reset
REQ-024 On reset SHALL immediately force c=0, fxa=0, fxb=0, busy=0, drop=0, pending=0, timer=0, state IDLE, including mid-PLAY.
REQ-025 The first ISSUE after reset release SHALL occur no earlier than the second clk edge after a request.

Configuration
REQ-026 With SFX_PREEMPT_EN defined, in PLAY or GAP a pending source with index above the currently playing source SHALL cause ISSUE on the next cycle, restarting the timer; the preempted effect is discarded.
REQ-027 Without SFX_PREEMPT_EN, SHALL never leave PLAY/GAP early; higher-priority requests wait in pending.

Structure
REQ-028 Source-to-effect table, state encoding, and fxa codes SHALL live in shared package sfx_pkg.
REQ-029 The priority selector SHALL be sub-module sfx_prio_enc (4-bit pending in, 2-bit index plus valid out, combinational).

Verification (SHORT_DUR=8, LONG_DUR=20, GAP_LEN=2)
REQ-030 req=0001 one cycle -> c pulse 2 cycles later, fxa=0, fxb=0, busy high 1+8+2=11 cycles.
REQ-031 req=0110 same cycle -> source 2 issued first (fxa=2), source 1 (fxa=1) issued 11 cycles later.
REQ-032 req[0] twice while pending -> drop pulses exactly once; only one effect plays.
REQ-033 source 0 playing, req=1000 at PLAY cycle 3 -> with SFX_PREEMPT_EN: c next cycle, fxa=2, fxb=1, busy lasts 23 more cycles; without: source 3 issues after GAP ends.
REQ-034 reset asserted mid-PLAY with pending=0100 -> c/busy/fxa/fxb drop to 0 asynchronously; no issue after release until new req.
REQ-035 req[3] in source-3 ISSUE cycle -> pending[3] stays set, drop=0, second long effect follows after GAP.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: FSM state encoding,
// effect frequency codes and the source-to-effect mapping.
package sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } sfx_state_t;

    localparam int TIMER_W = 15;

    localparam logic [3:0] FXA_PADDLE  = 4'd0;
    localparam logic [3:0] FXA_WALL    = 4'd1;
    localparam logic [3:0] FXA_WHISTLE = 4'd2;

    typedef struct packed {
        logic [3:0] fxa;
        logic       fxb;
    } sfx_effect_t;

    // Source id doubles as priority; both whistles share a tone, only length differs.
    function automatic sfx_effect_t src_effect(input logic [1:0] src);
        sfx_effect_t eff;
        case (src)
            2'd0:    eff = '{fxa: FXA_PADDLE,  fxb: 1'b0};
            2'd1:    eff = '{fxa: FXA_WALL,    fxb: 1'b0};
            2'd2:    eff = '{fxa: FXA_WHISTLE, fxb: 1'b0};
            default: eff = '{fxa: FXA_WHISTLE, fxb: 1'b1};
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/sfx_prio_enc.sv
// Combinational priority encoder: highest set pending bit wins.
module sfx_prio_enc (
    input  logic [3:0] pending,
    output logic [1:0] idx,
    output logic       valid
);

    always_comb begin
        valid = |pending;
        idx   = 2'd0;
        if (pending[3])      idx = 2'd3;
        else if (pending[2]) idx = 2'd2;
        else if (pending[1]) idx = 2'd1;
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: queues per-source requests and plays one effect at a time.
// Optional preemption by higher-priority sources when SFX_PREEMPT_EN is defined.
//
// state | meaning
// IDLE  | nothing playing, waiting for a pending request
// ISSUE | one-cycle trigger to the tone generator, timer loaded
// PLAY  | effect sounding, timer counts the play duration down
// GAP   | silent guard interval before the next effect
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int SHORT_DUR = 4096,
    parameter int LONG_DUR  = 32767,
    parameter int GAP_LEN   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic       c,
    output logic [3:0] fxa,
    output logic       fxb,
    output logic       busy,
    output logic       drop
);

    localparam logic [TIMER_W-1:0] SHORT_T = TIMER_W'(SHORT_DUR);
    localparam logic [TIMER_W-1:0] LONG_T  = TIMER_W'(LONG_DUR);
    localparam logic [TIMER_W-1:0] GAP_T   = TIMER_W'(GAP_LEN);

    sfx_state_t         state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [3:0]         pending, pending_nxt, issue_clr;
    logic [1:0]         cur_src, sel_idx;
    logic               sel_valid, load_sel, drop_nxt;
    sfx_effect_t        sel_eff;

    sfx_prio_enc u_prio (
        .pending (pending),
        .idx     (sel_idx),
        .valid   (sel_valid)
    );

    assign sel_eff = src_effect(sel_idx);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        load_sel  = 1'b0;
        issue_clr = '0;
        c         = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_nxt = ST_ISSUE;
                    load_sel  = 1'b1;
                end
            end
            ST_ISSUE: begin
                c                  = 1'b1;
                issue_clr[cur_src] = 1'b1;
                timer_nxt          = fxb ? LONG_T : SHORT_T;
                state_nxt          = ST_PLAY;
            end
            ST_PLAY: begin
                if (timer <= TIMER_W'(1)) begin
                    state_nxt = ST_GAP;
                    timer_nxt = GAP_T;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            ST_GAP: begin
                // Chain straight into the next issue so back-to-back effects skip IDLE.
                if (timer <= TIMER_W'(1)) begin
                    timer_nxt = '0;
                    if (sel_valid) begin
                        state_nxt = ST_ISSUE;
                        load_sel  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef SFX_PREEMPT_EN
        if ((state == ST_PLAY || state == ST_GAP) && sel_valid && (sel_idx > cur_src)) begin
            state_nxt = ST_ISSUE;
            load_sel  = 1'b1;
            timer_nxt = '0;
        end
`endif
        // A request landing on the bit being cleared keeps it set and is not a drop.
        pending_nxt = (pending & ~issue_clr) | req;
        drop_nxt    = |(req & pending & ~issue_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            pending <= '0;
            cur_src <= '0;
            fxa     <= '0;
            fxb     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
            drop    <= drop_nxt;
            if (load_sel) begin
                cur_src <= sel_idx;
                fxa     <= sel_eff.fxa;
                fxb     <= sel_eff.fxb;
            end
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler against a timeline-based reference model.
module tb_sfx_scheduler;

    localparam int SD = 8;
    localparam int LD = 20;
    localparam int GL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       c, fxb, busy, drop;
    logic [3:0] fxa;

    int checks = 0;
    int errors = 0;

    sfx_scheduler #(.SHORT_DUR(SD), .LONG_DUR(LD), .GAP_LEN(GL)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .c     (c),
        .fxa   (fxa),
        .fxb   (fxb),
        .busy  (busy),
        .drop  (drop)
    );

    always #5 clk = ~clk;

    // Reference model: an effect issued at cycle t keeps busy through t+dur+GL;
    // the scheduler picks the highest pending source once free (or, with
    // preemption, whenever a higher source than the playing one is pending).
    int         t, busy_end, cur, issue_src;
    bit         issue_now, drop_now;
    bit [3:0]   pend;
    logic [3:0] m_fxa;
    logic       m_fxb;

    task automatic model_reset();
        t = 0; busy_end = -1; cur = 0; issue_src = 0;
        issue_now = 0; drop_now = 0; pend = '0; m_fxa = '0; m_fxb = 1'b0;
    endtask

    function automatic int highest(input bit [3:0] p);
        for (int i = 3; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_advance(input logic [3:0] r);
        bit [3:0] np;
        bit nd, ni;
        int hi;
        np = pend; nd = 0; ni = 0;
        if (issue_now) begin
            np[issue_src] = 1'b0;
            busy_end = t + ((issue_src == 3) ? LD : SD) + GL;
            cur = issue_src;
        end
        for (int i = 0; i < 4; i++)
            if (r[i] && pend[i] && !(issue_now && i == issue_src)) nd = 1;
        np = np | r;
        hi = highest(pend);
        if (!issue_now && hi >= 0) begin
            if (t >= busy_end) ni = 1;
`ifdef SFX_PREEMPT_EN
            else if (hi > cur) ni = 1;
`endif
        end
        if (ni) begin
            issue_src = hi;
            m_fxa = (hi == 0) ? 4'd0 : (hi == 1) ? 4'd1 : 4'd2;
            m_fxb = (hi == 3);
        end
        pend = np; drop_now = nd; issue_now = ni; t++;
    endtask

    function automatic logic [7:0] exp_vec();
        return {issue_now, (issue_now || t <= busy_end), drop_now, m_fxa, m_fxb};
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({c, busy, drop, fxa, fxb} !== 8'h00) begin
            errors++; $display("FAIL reset_state act=%b exp=%b", {c, busy, drop, fxa, fxb}, 8'h00);
        end
        req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== 8'h00) begin
                errors++; $display("FAIL reset_hold k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, 8'h00);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b0000;
        model_reset();
    endtask

    task automatic test_single();
        int cpos[$];
        int nbusy = 0;
        for (int k = 0; k < 16; k++) begin
            req = (k == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL single k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (c) cpos.push_back(k);
            if (busy) nbusy++;
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (cpos.size() != 1 || cpos[0] != 2) begin
            errors++; $display("FAIL single_latency pulses=%0d first=%0d exp 1 pulse at 2", cpos.size(), (cpos.size() > 0) ? cpos[0] : -1);
        end
        checks++;
        if (nbusy != 1 + SD + GL) begin
            errors++; $display("FAIL single_busy_len act=%0d exp=%0d", nbusy, 1 + SD + GL);
        end
    endtask

    task automatic test_pair();
        int cpos[$];
        logic [3:0] cfx[$];
        for (int k = 0; k < 30; k++) begin
            req = (k == 0) ? 4'b0110 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL pair k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (c) begin cpos.push_back(k); cfx.push_back(fxa); end
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (cpos.size() != 2 || cpos[0] != 2 || cpos[1] != 13 || cfx[0] != 4'd2 || cfx[1] != 4'd1) begin
            errors++; $display("FAIL pair_order pulses=%0d exp 2 pulses at 2 (fxa 2) and 13 (fxa 1)", cpos.size());
        end
    endtask

    task automatic test_drop();
        int ndrop = 0;
        int nc = 0;
        for (int k = 0; k < 20; k++) begin
            req = (k < 2) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL drop k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (drop) ndrop++;
            if (c) nc++;
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (ndrop != 1 || nc != 1) begin
            errors++; $display("FAIL drop_count drops=%0d issues=%0d exp 1 and 1", ndrop, nc);
        end
    endtask

    task automatic test_preempt();
        int cpos[$];
        int exp_second;
`ifdef SFX_PREEMPT_EN
        exp_second = 7;
`else
        exp_second = 13;
`endif
        for (int k = 0; k < 40; k++) begin
            req = (k == 0) ? 4'b0001 : (k == 5) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL preempt k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (c) begin
                cpos.push_back(k);
                if (cpos.size() == 2) begin
                    checks++;
                    if ({fxa, fxb} !== 5'b0010_1) begin
                        errors++; $display("FAIL preempt_effect act=%b exp=%b", {fxa, fxb}, 5'b0010_1);
                    end
                end
            end
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (cpos.size() != 2 || cpos[1] != exp_second) begin
            errors++; $display("FAIL preempt_timing pulses=%0d second=%0d exp second at %0d", cpos.size(), (cpos.size() > 1) ? cpos[1] : -1, exp_second);
        end
    endtask

    task automatic test_same_src_issue();
        int cpos[$];
        int ndrop = 0;
        for (int k = 0; k < 50; k++) begin
            req = (k == 0 || k == 2) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL same_src k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (c) cpos.push_back(k);
            if (drop) ndrop++;
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (ndrop != 0 || cpos.size() != 2 || cpos[1] != 2 + LD + GL + 1) begin
            errors++; $display("FAIL same_src_requeue drops=%0d pulses=%0d exp 0 drops, 2nd issue at %0d", ndrop, cpos.size(), 2 + LD + GL + 1);
        end
    endtask

    task automatic test_reset_mid_play();
        int nc = 0;
        for (int k = 0; k < 8; k++) begin
            req = (k == 0) ? 4'b1000 : (k == 4) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL midreset_pre k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            model_advance(req);
            @(posedge clk); #1;
        end
        req = 4'b0000;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({c, busy, drop, fxa, fxb} !== 8'h00) begin
            errors++; $display("FAIL midreset_async act=%b exp=%b", {c, busy, drop, fxa, fxb}, 8'h00);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL midreset_post k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            if (c) nc++;
            model_advance(req);
            @(posedge clk); #1;
        end
        checks++;
        if (nc != 0) begin
            errors++; $display("FAIL midreset_no_issue issues=%0d exp=0", nc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            @(negedge clk);
            checks++;
            if ({c, busy, drop, fxa, fxb} !== exp_vec()) begin
                errors++; $display("FAIL random k=%0d act=%b exp=%b", k, {c, busy, drop, fxa, fxb}, exp_vec());
            end
            model_advance(req);
            @(posedge clk); #1;
        end
        req = 4'b0000;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_pair();
        test_drop();
        test_preempt();
        test_same_src_issue();
        test_reset_mid_play();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
